id_ex_control_stage: RTL and testbench

- Parametrised successor of the combinational opcode decoder.
- Decodes the ID-stage instruction into the full control bundle and registers it into the ID/EX pipeline register, with valid, hold, flush and bubble handling.
- Detects load-use hazards against the instruction currently in EX and requests an upstream stall.
- Supports optional I-ALU and JAL opcodes and keeps a saturating illegal-opcode counter.
- Sits between the IF/ID register and the EX stage.

---
 rtl/id_ex_control_stage_pkg.sv | 42 ++++
 rtl/id_ex_control_stage_ctrl_decode.sv | 83 ++++++++
 rtl/id_ex_control_stage.sv | 110 +++++++++++
 tb/tb_id_ex_control_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_control_stage_pkg.sv
// ============================================================================
// id_ex_control_stage_pkg -- opcodes, immsel/aluop encodings, control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

package id_ex_control_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       jump;
    logic [2:0] immsel;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/id_ex_control_stage_ctrl_decode.sv
// ============================================================================
// ctrl_decode -- combinational opcode decode into the control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
  import id_ex_control_stage_pkg::*;
#(
  parameter bit ENABLE_IALU = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       illegal
);

  always_comb begin
    ctrl     = CTRL_NOP;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = ALU_R;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_LOAD: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.immsel   = IMM_I;
        ctrl.aluop    = ALU_ADD;
        uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.immsel   = IMM_S;
        ctrl.aluop    = ALU_ADD;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.immsel = IMM_B;
        ctrl.aluop  = ALU_BR;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_IALU: begin
        if (ENABLE_IALU) begin
          ctrl.regwrite = 1'b1;
          ctrl.alusrc   = 1'b1;
          ctrl.immsel   = IMM_I;
          ctrl.aluop    = ALU_I;
          uses_rs1      = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        // rs fields of JAL are immediate bits, so no source use is reported
        if (ENABLE_JAL) begin
          ctrl.regwrite = 1'b1;
          ctrl.jump     = 1'b1;
          ctrl.immsel   = IMM_J;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_control_stage.sv
// ============================================================================
// id_ex_control_stage -- ID/EX control register with load-use stall, bubble,
// hold/flush handling and a saturating illegal-opcode counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module id_ex_control_stage
  import id_ex_control_stage_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter bit ENABLE_IALU = 1'b1,
  parameter bit ENABLE_JAL  = 1'b1,
  parameter int ILL_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 ex_hold,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic                 ex_valid,
  output logic                 ex_regwrite,
  output logic                 ex_alusrc,
  output logic                 ex_memread,
  output logic                 ex_memwrite,
  output logic                 ex_memtoreg,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic [2:0]           ex_immsel,
  output logic [1:0]           ex_aluop,
  output logic [REG_AW-1:0]    ex_rd,
  output logic [REG_AW-1:0]    ex_rs1,
  output logic [REG_AW-1:0]    ex_rs2,
  output logic [ILL_CNT_W-1:0] ill_count
);

  ctrl_t             dec_ctrl;
  ctrl_t             ex_ctrl;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              illegal;
  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;

  assign id_rd  = REG_AW'(id_instr[11:7]);
  assign id_rs1 = REG_AW'(id_instr[19:15]);
  assign id_rs2 = REG_AW'(id_instr[24:20]);

  ctrl_decode #(
    .ENABLE_IALU (ENABLE_IALU),
    .ENABLE_JAL  (ENABLE_JAL)
  ) u_ctrl_decode (
    .opcode   (id_instr[6:0]),
    .ctrl     (dec_ctrl),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .illegal  (illegal)
  );

  assign hazard_stall = id_valid & ex_valid & ex_ctrl.memread & (ex_rd != '0) &
                        ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));

  // Priority: flush > hold > hazard bubble > normal load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= CTRL_NOP;
      ex_rd     <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      ill_count <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (ex_hold) begin
      ex_valid <= ex_valid;
    end else if (hazard_stall) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
      ex_rd    <= id_rd;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
    end else begin
      ex_valid <= id_valid & ~illegal;
      ex_ctrl  <= id_valid ? dec_ctrl : CTRL_NOP;
      ex_rd    <= id_rd;
      ex_rs1   <= id_rs1;
      ex_rs2   <= id_rs2;
      if (id_valid && illegal && (ill_count != '1)) begin
        ill_count <= ill_count + ILL_CNT_W'(1);
      end
    end
  end

  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_jump     = ex_ctrl.jump;
  assign ex_immsel   = ex_ctrl.immsel;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_control_stage.sv
// ============================================================================
// tb_id_ex_control_stage -- directed bench for id_ex_control_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_control_stage;

  localparam logic [6:0] T_R      = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_IALU   = 7'b0010011;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_ILL    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid, ex_hold, flush;

  logic       hazard_stall, ex_valid, ex_regwrite, ex_alusrc, ex_memread, ex_memwrite;
  logic       ex_memtoreg, ex_branch, ex_jump;
  logic [2:0] ex_immsel;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic [7:0] ill_count;

  logic       b_hazard_stall, b_ex_valid, b_ex_regwrite, b_ex_alusrc, b_ex_memread, b_ex_memwrite;
  logic       b_ex_memtoreg, b_ex_branch, b_ex_jump;
  logic [2:0] b_ex_immsel;
  logic [1:0] b_ex_aluop;
  logic [4:0] b_ex_rd, b_ex_rs1, b_ex_rs2;
  logic [1:0] b_ill_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_control_stage dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_hold(ex_hold), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_immsel(ex_immsel),
    .ex_aluop(ex_aluop), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ill_count(ill_count)
  );

  id_ex_control_stage #(.ENABLE_JAL(1'b0), .ILL_CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
    .ex_hold(ex_hold), .flush(flush), .hazard_stall(b_hazard_stall),
    .ex_valid(b_ex_valid), .ex_regwrite(b_ex_regwrite), .ex_alusrc(b_ex_alusrc),
    .ex_memread(b_ex_memread), .ex_memwrite(b_ex_memwrite), .ex_memtoreg(b_ex_memtoreg),
    .ex_branch(b_ex_branch), .ex_jump(b_ex_jump), .ex_immsel(b_ex_immsel),
    .ex_aluop(b_ex_aluop), .ex_rd(b_ex_rd), .ex_rs1(b_ex_rs1), .ex_rs2(b_ex_rs2),
    .ill_count(b_ill_count)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; id_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0; id_instr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    reset_pulse();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_init_valid: got %0b expected 0", ex_valid); end
    checks++; if (ill_count !== 8'd0) begin errors++; $display("FAIL rst_init_ill: got %0d expected 0", ill_count); end
    id_instr = mk(T_ILL, 5'd1, 5'd2, 5'd3); id_valid = 1'b1;
    tick();
    id_instr = mk(T_LOAD, 5'd3, 5'd1, 5'd0);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0b expected 1", ex_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b expected 0", ex_valid); end
    checks++; if ({ex_regwrite, ex_memread, ex_alusrc, ex_memtoreg} !== 4'b0) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 0000", {ex_regwrite, ex_memread, ex_alusrc, ex_memtoreg}); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL rst_async_rd: got %0d expected 0", ex_rd); end
    checks++; if (ill_count !== 8'd0) begin errors++; $display("FAIL rst_async_ill: got %0d expected 0", ill_count); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_async_hazard: got %0b expected 0", hazard_stall); end
    tick();
    rst = 1'b0; id_valid = 1'b0;
  endtask

  task automatic test_rtype();
    id_instr = mk(T_R, 5'd3, 5'd1, 5'd2); id_valid = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL r_valid: got %0b expected 1", ex_valid); end
    checks++; if (ex_regwrite !== 1'b1) begin errors++; $display("FAIL r_regwrite: got %0b expected 1", ex_regwrite); end
    checks++; if (ex_aluop !== 2'b10) begin errors++; $display("FAIL r_aluop: got %b expected 10", ex_aluop); end
    checks++; if (ex_alusrc !== 1'b0) begin errors++; $display("FAIL r_alusrc: got %0b expected 0", ex_alusrc); end
    checks++; if ({ex_rd, ex_rs1, ex_rs2} !== {5'd3, 5'd1, 5'd2}) begin errors++; $display("FAIL r_fields: got %0d/%0d/%0d expected 3/1/2", ex_rd, ex_rs1, ex_rs2); end
  endtask

  task automatic test_load_use();
    id_instr = mk(T_LOAD, 5'd5, 5'd1, 5'd0); id_valid = 1'b1;
    tick();
    checks++; if ({ex_memread, ex_memtoreg, ex_alusrc, ex_immsel} !== 6'b111_000) begin errors++; $display("FAIL lw_ctrl: got %b expected 111000", {ex_memread, ex_memtoreg, ex_alusrc, ex_immsel}); end
    id_instr = mk(T_R, 5'd6, 5'd5, 5'd2);
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b expected 1", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_memread, ex_regwrite} !== 3'b000) begin errors++; $display("FAIL lu_bubble: got %b expected 000", {ex_valid, ex_memread, ex_regwrite}); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %0b expected 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_regwrite, ex_rd} !== {2'b11, 5'd6}) begin errors++; $display("FAIL lu_add_enters: got %b expected 1100110", {ex_valid, ex_regwrite, ex_rd}); end
    // store rs2 against a load rd
    id_instr = mk(T_LOAD, 5'd5, 5'd1, 5'd0);
    tick();
    id_instr = mk(T_STORE, 5'd0, 5'd1, 5'd5);
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_rs2_stall: got %0b expected 1", hazard_stall); end
    tick();
    tick();
    checks++; if ({ex_valid, ex_memwrite} !== 2'b11) begin errors++; $display("FAIL lu_store_enters: got %b expected 11", {ex_valid, ex_memwrite}); end
    // load into x0 never stalls
    id_instr = mk(T_LOAD, 5'd0, 5'd1, 5'd0);
    tick();
    id_instr = mk(T_R, 5'd6, 5'd0, 5'd0);
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_x0: got %0b expected 0", hazard_stall); end
    tick();
  endtask

  task automatic test_hold_flush();
    id_instr = mk(T_STORE, 5'd0, 5'd3, 5'd4); id_valid = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_memwrite, ex_immsel} !== 5'b11_001) begin errors++; $display("FAIL st_load: got %b expected 11001", {ex_valid, ex_memwrite, ex_immsel}); end
    ex_hold = 1'b1; id_instr = mk(T_R, 5'd9, 5'd7, 5'd8);
    tick();
    checks++; if ({ex_valid, ex_memwrite, ex_regwrite, ex_rs1} !== {3'b110, 5'd3}) begin errors++; $display("FAIL hold_keep: got %b expected 11000011", {ex_valid, ex_memwrite, ex_regwrite, ex_rs1}); end
    flush = 1'b1;
    tick();
    checks++; if ({ex_valid, ex_memwrite} !== 2'b00) begin errors++; $display("FAIL hold_flush: got %b expected 00", {ex_valid, ex_memwrite}); end
    ex_hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_illegal();
    logic [1:0] exp_b;
    reset_pulse();
    id_instr = mk(T_ILL, 5'd1, 5'd2, 5'd3); id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_b = (i < 2) ? 2'(i + 1) : 2'd3;
      checks++; if (b_ill_count !== exp_b) begin errors++; $display("FAIL ill_sat[%0d]: got %0d expected %0d", i, b_ill_count, exp_b); end
      checks++; if (ill_count !== 8'(i + 1)) begin errors++; $display("FAIL ill_cnt[%0d]: got %0d expected %0d", i, ill_count, i + 1); end
      checks++; if (b_ex_valid !== 1'b0) begin errors++; $display("FAIL ill_valid[%0d]: got %0b expected 0", i, b_ex_valid); end
    end
    id_valid = 1'b0;
    tick();
    checks++; if (ill_count !== 8'd5) begin errors++; $display("FAIL ill_novalid: got %0d expected 5", ill_count); end
    id_valid = 1'b1; flush = 1'b1;
    tick();
    checks++; if (ill_count !== 8'd5) begin errors++; $display("FAIL ill_flush: got %0d expected 5", ill_count); end
    flush = 1'b0; ex_hold = 1'b1;
    tick();
    checks++; if (ill_count !== 8'd5) begin errors++; $display("FAIL ill_hold: got %0d expected 5", ill_count); end
    ex_hold = 1'b0; id_valid = 1'b0;
  endtask

  task automatic test_jal_ialu();
    reset_pulse();
    id_instr = mk(T_LOAD, 5'd5, 5'd1, 5'd0); id_valid = 1'b1;
    tick();
    id_instr = mk(T_JAL, 5'd1, 5'd5, 5'd5);
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL jal_nohazard: got %0b expected 0", hazard_stall); end
    tick();
    checks++; if ({ex_valid, ex_jump, ex_regwrite, ex_immsel} !== 6'b111_011) begin errors++; $display("FAIL jal_ctrl: got %b expected 111011", {ex_valid, ex_jump, ex_regwrite, ex_immsel}); end
    checks++; if (ill_count !== 8'd0) begin errors++; $display("FAIL jal_legal_cnt: got %0d expected 0", ill_count); end
    checks++; if ({b_ill_count, b_ex_valid, b_ex_jump} !== 4'b0100) begin errors++; $display("FAIL jal_disabled: got %b expected 0100", {b_ill_count, b_ex_valid, b_ex_jump}); end
    id_instr = mk(T_LOAD, 5'd5, 5'd1, 5'd0);
    tick();
    id_instr = mk(T_IALU, 5'd7, 5'd5, 5'd0);
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL ialu_stall: got %0b expected 1", hazard_stall); end
    tick();
    tick();
    checks++; if ({ex_valid, ex_regwrite, ex_alusrc, ex_aluop, ex_immsel} !== 8'b111_11_000) begin errors++; $display("FAIL ialu_ctrl: got %b expected 11111000", {ex_valid, ex_regwrite, ex_alusrc, ex_aluop, ex_immsel}); end
    id_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_instr = '0; id_valid = 1'b0; ex_hold = 1'b0; flush = 1'b0;
    test_reset();
    test_rtype();
    test_load_use();
    test_hold_flush();
    test_illegal();
    test_jal_ialu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
